tile_board_ctrl: RTL and testbench
==================================

// Module: tile_board_ctrl
// PURPOSE
//  Game-state stage directly upstream of the tile renderer. Holds the 3-row x 4-column "white tile" board.
//  Scores player key hits against the bottom row and scrolls the board down on each hit.
//  Publishes the board as one 12-bit word with three 4-bit black-tile addresses, addr = row*4 + col.
//  The renderer latches this word as datafromCPU. The word changes only on frame boundaries, so no frame shows a torn board.
// PARAMETERS
//  TIMEOUT_CYCLES  50_000_000  max clk cycles allowed between hits in PLAY; exceeding it ends the game
//  LFSR_SEED       16'hACE1    LFSR reset value; a zero value is replaced by 16'h0001
//  SCORE_W         16          score counter width
// PORTS
//  clk        in   1        system clock; all logic on posedge
//  rst_n      in   1        synchronous reset, active-low
//  start      in   1        1-cycle pulse: begin or restart a game
//  key_valid  in   1        1-cycle pulse: player pressed a column key
//  key_col    in   2        column of the press, 0..3, valid with key_valid
//  frame_tick in   1        1-cycle pulse at start of vertical blank from the VGA timing stage
//  pos        out  12       board word to renderer: [11:8] top row (8..11), [7:4] middle (4..7), [3:0] bottom (0..3)
//  score      out  SCORE_W  hits in current game, saturating at all-ones
//  game_over  out  1        high in OVER state
//  playing    out  1        high in PLAY state
// BEHAVIOUR
//  Reset values: pos=12'hFFF (blank; F never matches any render addr), score=0, game_over=0, playing=0.
//  Reset also sets: FSM=IDLE, shadow=12'hFFF, timer=0, lfsr=LFSR_SEED.
//  LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1. Shifts every cycle in every state, so game seed depends on start timing.
//  Shadow board shadow[11:0] is updated by the FSM. pos <= shadow only on a cycle with frame_tick=1.
//  Commit uses the pre-edge shadow. A shadow update in the same cycle appears at the next frame_tick.
//  FSM states: IDLE, PLAY, OVER.
//   IDLE: key_valid ignored. start -> fill board, clear score/timer -> PLAY.
//   PLAY, key_valid and key_col==shadow[1:0]: hit. score+1 (saturating), timer=0.
//    Scroll: bottom<=middle-4, middle<=top-4, top<=8+newcol.
//   PLAY, key_valid and key_col!=shadow[1:0]: miss -> OVER.
//   PLAY, no key_valid: timer+1. When timer reaches TIMEOUT_CYCLES-1 -> OVER.
//   PLAY, hit and timeout in the same cycle: the hit wins and the timer clears.
//   OVER: board and score frozen, key_valid ignored. start -> fill, clear score/timer -> PLAY.
//   start has priority over key_valid in every state. start in PLAY restarts the game.
//  Fill: bottom=lfsr[1:0], middle=4+c1, top=8+c2.
//   c1=lfsr[3:2], except c1=lfsr[3:2]+1 mod 4 if that equals lfsr[1:0].
//   c2 follows the same rule against c1, using lfsr[5:4].
//  Adjacency rule for newcol: newcol=lfsr[1:0]; if it equals the current top column (shadow[9:8]) use +1 mod 4.
//  Result: vertically adjacent black tiles never share a column.
//  Row nibbles are always legal, in IDLE too: bottom 0..3, middle 4..7, top 8..11, or the blank F.
//  Subtracting 4 never wraps.
//  Latency: key_valid at edge N updates shadow at N+1. pos shows it after the first frame_tick at or after N+1.
//  score, game_over and playing update at N+1, not frame-synced.
//  rst_n low in any state forces reset values on the next edge. It overrides start, key_valid and frame_tick.
// STRUCTURE
//  Shared package tile_pkg holds:
//   state encoding (IDLE=2'd0, PLAY=2'd1, OVER=2'd2)
//   ROW_BOT=4'd0, ROW_MID=4'd4, ROW_TOP=4'd8, NIBBLE_BLANK=4'hF, NUM_COLS=4
//   function next_col(cand,prev) implementing the adjacency rule.
//  Sub-module tile_lfsr (clk, rst_n, seed param, q[15:0]).
//  FSM, timer, score and the shadow/pos registers stay in this module.
// TESTING
//  Reset: rst_n=0 for 2 cycles -> pos=12'hFFF, score=0, game_over=0, playing=0. Remains so with frame_tick pulses in IDLE.
//  Start + frame sync: start, no frame_tick for 10 cycles -> pos stays 12'hFFF.
//   Next frame_tick -> pos[3:0] in 0..3, [7:4] in 4..7, [11:8] in 8..11, adjacent columns differ, playing=1.
//  Hit scroll: key_col=pos[1:0] -> score=1. After frame_tick: new pos[3:0]=old pos[7:4]-4, new pos[7:4]=old pos[11:8]-4.
//   New pos[9:8] differs from old pos[9:8].
//  Miss: key_col=(pos[1:0]+1)%4 -> game_over=1, playing=0.
//   Further key_valid and frame_tick leave pos and score frozen. start -> score=0, playing=1.
//  Timeout with TIMEOUT_CYCLES=16: no key for 15 cycles -> game_over=1 exactly on cycle 16.
//   Hit on the timeout cycle -> stays in PLAY, score+1.
//  Priority/reset: start and wrong-column key_valid in the same cycle -> PLAY, score=0.
//   rst_n=0 mid-PLAY with frame_tick=1 -> pos=12'hFFF, score=0.
//   Score saturation with SCORE_W=4: 20 hits -> score=4'hF.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared definitions for the white-tile board controller: state codes,
// row base addresses and the column adjacency helper.
package tile_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam logic [3:0] ROW_BOT      = 4'd0;
  localparam logic [3:0] ROW_MID      = 4'd4;
  localparam logic [3:0] ROW_TOP      = 4'd8;
  localparam logic [3:0] NIBBLE_BLANK = 4'hF;
  localparam int         NUM_COLS     = 4;

  // Bump a candidate column by one (mod 4) when it would sit under the previous one.
  function automatic logic [1:0] next_col(input logic [1:0] cand, input logic [1:0] prev);
    logic [1:0] col;
    if (cand == prev) begin
      col = cand + 2'd1;
    end else begin
      col = cand;
    end
    return col;
  endfunction

endpackage

// File: rtl/tile_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, right-shifting.
module tile_lfsr #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  // An all-zero state would lock the register up, so it is never loaded.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic feedback_s;

  assign feedback_s = q[0] ^ q[2] ^ q[3] ^ q[5];

  // Shift every cycle regardless of game state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= SEED_EFF;
    end else begin
      q <= {feedback_s, q[15:1]};
    end
  end

endmodule

// File: rtl/tile_board_ctrl.sv
// Game-state stage for the tile renderer: scores hits against the bottom row,
// scrolls the shadow board and publishes it to the renderer on frame boundaries.
module tile_board_ctrl
  import tile_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 50_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          SCORE_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               key_valid,
  input  logic [1:0]         key_col,
  input  logic               frame_tick,
  output logic [11:0]        pos,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               playing
);

  localparam int                   TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SCORE_W-1:0]   SCORE_MAX  = {SCORE_W{1'b1}};

  logic [15:0]        lfsr_s;
  logic               unused_lfsr_s;
  logic [1:0]         state_r, state_s;
  logic [11:0]        shadow_r, shadow_s;
  logic [SCORE_W-1:0] score_r, score_s;
  logic [TIMER_W-1:0] timer_r, timer_s;
  logic [11:0]        pos_r;
  logic               game_over_r, playing_r;
  logic [1:0]         c0_s, c1_s, c2_s, new_col_s;
  logic [11:0]        fill_s, scroll_s;

  tile_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_s)
  );

  assign unused_lfsr_s = ^lfsr_s[15:6];

  // Fresh board: each row's column chosen so no two stacked rows share a column.
  assign c0_s     = lfsr_s[1:0];
  assign c1_s     = next_col(lfsr_s[3:2], c0_s);
  assign c2_s     = next_col(lfsr_s[5:4], c1_s);
  assign fill_s   = {ROW_TOP + {2'b00, c2_s}, ROW_MID + {2'b00, c1_s}, ROW_BOT + {2'b00, c0_s}};
  assign new_col_s = next_col(lfsr_s[1:0], shadow_r[9:8]);
  assign scroll_s = {ROW_TOP + {2'b00, new_col_s}, shadow_r[11:8] - ROW_MID, shadow_r[7:4] - ROW_MID};

  // Next-state logic; start outranks every key event in every state.
  always_comb begin
    state_s  = state_r;
    shadow_s = shadow_r;
    score_s  = score_r;
    timer_s  = timer_r;
    if (start) begin
      state_s  = ST_PLAY;
      shadow_s = fill_s;
      score_s  = '0;
      timer_s  = '0;
    end else begin
      case (state_r)
        ST_PLAY: begin
          if (key_valid) begin
            if (key_col == shadow_r[1:0]) begin
              shadow_s = scroll_s;
              score_s  = (score_r == SCORE_MAX) ? score_r : score_r + SCORE_W'(1);
              timer_s  = '0;
            end else begin
              state_s = ST_OVER;
            end
          end else if (timer_r == TIMER_LAST) begin
            state_s = ST_OVER;
          end else begin
            timer_s = timer_r + TIMER_W'(1);
          end
        end
        ST_IDLE, ST_OVER: begin
          state_s = state_r;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State registers; pos only takes the pre-edge shadow on a frame tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      shadow_r    <= {3{NIBBLE_BLANK}};
      score_r     <= '0;
      timer_r     <= '0;
      pos_r       <= {3{NIBBLE_BLANK}};
      game_over_r <= 1'b0;
      playing_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      shadow_r    <= shadow_s;
      score_r     <= score_s;
      timer_r     <= timer_s;
      pos_r       <= frame_tick ? shadow_r : pos_r;
      game_over_r <= (state_s == ST_OVER);
      playing_r   <= (state_s == ST_PLAY);
    end
  end

  assign pos       = pos_r;
  assign score     = score_r;
  assign game_over = game_over_r;
  assign playing   = playing_r;

endmodule

// File: tb/tb_tile_board_ctrl.sv
// Self-checking bench for tile_board_ctrl: reference model feeding a scoreboard,
// a vector table for the main flow and hand-written corner-case sequences.
module tb_tile_board_ctrl;

  localparam int          TO   = 16;
  localparam int          SW   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, start = 1'b0, key_valid = 1'b0, frame_tick = 1'b0;
  logic [1:0]    key_col = 2'd0;
  logic [11:0]   pos;
  logic [SW-1:0] score;
  logic          game_over, playing;

  tile_board_ctrl #(.TIMEOUT_CYCLES(TO), .LFSR_SEED(SEED), .SCORE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_valid(key_valid), .key_col(key_col),
    .frame_tick(frame_tick), .pos(pos), .score(score), .game_over(game_over), .playing(playing)
  );

  always #5 clk = ~clk;

  // Reference model state (value after the most recent clock edge)
  logic [15:0]   m_lfsr;
  int            m_state;
  logic [11:0]   m_shadow, m_pos;
  logic [SW-1:0] m_score;
  int            m_timer;

  typedef struct {
    logic [11:0]   pos;
    logic [SW-1:0] score;
    logic          over;
    logic          play;
  } exp_t;

  typedef struct {
    logic          st;
    logic [1:0]    ksel;   // 0 none, 1 hit, 2 miss
    logic          ft;
    logic [SW-1:0] score;
    logic          over;
    logic          play;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[22];
  int   n_cmp = 0, n_fail = 0;

  function automatic logic [1:0] adj(input logic [1:0] c, input logic [1:0] p);
    if (c == p) return c + 2'd1;
    return c;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic st, input logic kv, input logic [1:0] kc,
                            input logic ft, input logic rn);
    logic [15:0] l;
    logic [1:0]  a, b, c;
    l = m_lfsr;
    if (!rn) begin
      m_lfsr = SEED; m_state = 0; m_shadow = 12'hFFF; m_pos = 12'hFFF;
      m_score = '0; m_timer = 0;
      return;
    end
    if (ft) m_pos = m_shadow;
    if (st) begin
      a = l[1:0]; b = adj(l[3:2], a); c = adj(l[5:4], b);
      m_shadow = {2'b10, c, 2'b01, b, 2'b00, a};
      m_score = '0; m_timer = 0; m_state = 1;
    end else if (m_state == 1) begin
      if (kv) begin
        if (kc == m_shadow[1:0]) begin
          a = adj(l[1:0], m_shadow[9:8]);
          m_shadow = {4'd8 + {2'b00, a}, m_shadow[11:8] - 4'd4, m_shadow[7:4] - 4'd4};
          if (m_score != {SW{1'b1}}) m_score = m_score + 1'b1;
          m_timer = 0;
        end else begin
          m_state = 2;
        end
      end else if (m_timer == TO - 1) begin
        m_state = 2;
      end else begin
        m_timer++;
      end
    end
    m_lfsr = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endtask

  // Drive one cycle of inputs, predict, then compare after the edge.
  task automatic apply(input logic st, input logic kv, input logic [1:0] kc,
                       input logic ft, input logic rn);
    exp_t e;
    start = st; key_valid = kv; key_col = kc; frame_tick = ft; rst_n = rn;
    model_step(st, kv, kc, ft, rn);
    e.pos = m_pos; e.score = m_score; e.over = (m_state == 2); e.play = (m_state == 1);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 16'd1, 16'd0);
    end else begin
      e = sb_q.pop_front();
      check("sb_pos", {4'h0, pos}, {4'h0, e.pos});
      check("sb_score", {12'h0, score}, {12'h0, e.score});
      check("sb_over", {15'h0, game_over}, {15'h0, e.over});
      check("sb_play", {15'h0, playing}, {15'h0, e.play});
    end
  endtask

  task automatic idle(input logic ft);
    apply(1'b0, 1'b0, 2'd0, ft, 1'b1);
  endtask

  task automatic hit(input logic ft);
    apply(1'b0, 1'b1, m_shadow[1:0], ft, 1'b1);
  endtask

  task automatic check_legal();
    check("bot_range", {15'h0, pos[3:0] <= 4'd3}, 16'd1);
    check("mid_range", {15'h0, pos[7:4] >= 4'd4 && pos[7:4] <= 4'd7}, 16'd1);
    check("top_range", {15'h0, pos[11:8] >= 4'd8 && pos[11:8] <= 4'd11}, 16'd1);
    check("adj_bm", {15'h0, pos[1:0] != pos[5:4]}, 16'd1);
    check("adj_mt", {15'h0, pos[5:4] != pos[9:8]}, 16'd1);
  endtask

  initial begin
    logic [11:0] old_pos;
    logic [1:0]  kc;

    // Reset and idle with frame ticks
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    check("rst_pos", {4'h0, pos}, 16'h0FFF);
    check("rst_score", {12'h0, score}, 16'd0);
    check("rst_flags", {14'h0, game_over, playing}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("idle_pos", {4'h0, pos}, 16'h0FFF);
      check("idle_play", {15'h0, playing}, 16'd0);
    end

    // Start, no frame tick for 10 cycles, then commit
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      check("nosync_pos", {4'h0, pos}, 16'h0FFF);
    end
    idle(1'b1);
    check("sync_play", {15'h0, playing}, 16'd1);
    check_legal();

    // Hit and scroll
    old_pos = pos;
    hit(1'b0);
    check("hit_score", {12'h0, score}, 16'd1);
    idle(1'b1);
    check("scroll_bot", {12'h0, pos[3:0]}, {12'h0, old_pos[7:4] - 4'd4});
    check("scroll_mid", {12'h0, pos[7:4]}, {12'h0, old_pos[11:8] - 4'd4});
    check("scroll_topcol", {15'h0, pos[9:8] != old_pos[9:8]}, 16'd1);
    check_legal();

    // Miss, then frozen in OVER, then restart
    kc = pos[1:0] + 2'd1;
    apply(1'b0, 1'b1, kc, 1'b0, 1'b1);
    check("miss_flags", {14'h0, game_over, playing}, 16'd2);
    old_pos = pos;
    kc = pos[1:0];
    apply(1'b0, 1'b1, kc, 1'b1, 1'b1);
    check("over_pos", {4'h0, pos}, {4'h0, old_pos});
    check("over_score", {12'h0, score}, 16'd1);
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    check("restart_score", {12'h0, score}, 16'd0);
    check("restart_play", {15'h0, playing}, 16'd1);

    // Table-driven main flow from a fresh reset
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tbl[0]  = '{1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1};
    for (int i = 3; i < 8; i++) tbl[i] = '{1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 2'd1, 1'b0, 4'd1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 4'd1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 2'd1, 1'b1, 4'd2, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 2'd0, 1'b1, 4'd2, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 2'd1, 1'b0, 4'd3, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 2'd0, 1'b1, 4'd3, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 2'd2, 1'b0, 4'd3, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 2'd1, 1'b1, 4'd3, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 2'd0, 1'b1, 4'd3, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 2'd2, 1'b0, 4'd0, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 2'd1, 1'b1, 4'd1, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 2'd0, 1'b1, 4'd1, 1'b0, 1'b1};
    for (int i = 0; i < 22; i++) begin
      kc = (tbl[i].ksel == 2'd2) ? m_shadow[1:0] + 2'd1 : m_shadow[1:0];
      apply(tbl[i].st, tbl[i].ksel != 2'd0, kc, tbl[i].ft, 1'b1);
      check("tbl_score", {12'h0, score}, {12'h0, tbl[i].score});
      check("tbl_over", {15'h0, game_over}, {15'h0, tbl[i].over});
      check("tbl_play", {15'h0, playing}, {15'h0, tbl[i].play});
    end

    // Timeout: game_over exactly after the 16th idle cycle
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      idle(1'b0);
      check("timeout_over", {15'h0, game_over}, {15'h0, i == 16});
      check("timeout_play", {15'h0, playing}, {15'h0, i != 16});
    end

    // Hit on the timeout cycle wins
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) idle(1'b0);
    hit(1'b0);
    check("to_hit_play", {14'h0, game_over, playing}, 16'd1);
    check("to_hit_score", {12'h0, score}, 16'd1);

    // Score saturation
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) hit(1'b0);
    check("sat_score", {12'h0, score}, 16'h000F);
    check("sat_play", {15'h0, playing}, 16'd1);

    // Reset mid-PLAY overrides a frame tick
    apply(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    check("rst_play_pos", {4'h0, pos}, 16'h0FFF);
    check("rst_play_score", {12'h0, score}, 16'd0);
    check("rst_play_flags", {14'h0, game_over, playing}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
